// File: rtl/bp_sac_io_cmd_arbiter.sv
// Round-robin arbiter sharing one SAC I/O command/response channel among several requesters.
// Requester IDs of granted commands are queued in order so each response returns to its issuer.
module bp_sac_io_cmd_arbiter #(
    parameter  int num_req_p         = 4,
    parameter  int msg_width_p       = 32,
    parameter  int max_outstanding_p = 4,
    localparam int id_width_lp       = (num_req_p > 1) ? $clog2(num_req_p) : 1,
    localparam int cnt_width_lp      = $clog2(max_outstanding_p + 1)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,

    input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
    input  logic [num_req_p-1:0]             req_cmd_v_i,
    output logic [num_req_p-1:0]             req_cmd_yumi_o,

    output logic [msg_width_p-1:0]           req_resp_o,
    output logic [num_req_p-1:0]             req_resp_v_o,
    input  logic [num_req_p-1:0]             req_resp_ready_i,

    output logic [msg_width_p-1:0]           io_cmd_o,
    output logic                             io_cmd_v_o,
    input  logic                             io_cmd_ready_i,

    input  logic [msg_width_p-1:0]           io_resp_i,
    input  logic                             io_resp_v_i,
    output logic                             io_resp_yumi_o,

    output logic [cnt_width_lp-1:0]          outstanding_o,
    output logic                             error_o
);

    localparam int ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

    logic [id_width_lp-1:0]  rr_q;
    logic [id_width_lp-1:0]  sel;
    logic                    found;
    logic [ptr_width_lp-1:0] wr_ptr_q, rd_ptr_q;
    logic [cnt_width_lp-1:0] count_q;
    logic                    error_q;
    logic [id_width_lp-1:0]  tag_mem [max_outstanding_p];
    logic [id_width_lp-1:0]  head;
    logic                    empty;
    logic                    push, pop, spurious;
    logic [msg_width_p-1:0]  cmd_arr [num_req_p];

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(max_outstanding_p - 1)) ? '0 : p + ptr_width_lp'(1);
    endfunction

    for (genvar g = 0; g < num_req_p; g++) begin : g_cmd
        assign cmd_arr[g] = req_cmd_i[g*msg_width_p +: msg_width_p];
    end

    // Scan requesters starting at rr_q; the first valid one found wins.
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        logic [id_width_lp-1:0] cand;
        sel   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < num_req_p; i++) begin
            cand = id_width_lp'((int'(rr_q) + i) % num_req_p);
            if (!found && req_cmd_v_i[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    // Credit check uses the registered count, so a pop cannot free a slot in the same cycle.
    assign io_cmd_v_o = found && (count_q < cnt_width_lp'(max_outstanding_p));
    assign io_cmd_o   = cmd_arr[sel];
    assign push       = io_cmd_v_o && io_cmd_ready_i;

    always_comb begin
        req_cmd_yumi_o = '0;
        if (push) begin
            req_cmd_yumi_o[sel] = 1'b1;
        end
    end

    assign empty      = (count_q == '0);
    assign head       = tag_mem[rd_ptr_q];
    assign req_resp_o = io_resp_i;

    // With nothing outstanding a response has no owner: swallow it and flag the error.
    always_comb begin
        req_resp_v_o   = '0;
        io_resp_yumi_o = 1'b0;
        if (!empty) begin
            req_resp_v_o[head] = io_resp_v_i;
            io_resp_yumi_o     = io_resp_v_i && req_resp_ready_i[head];
        end else begin
            io_resp_yumi_o = io_resp_v_i;
        end
    end

    assign pop      = !empty && io_resp_yumi_o;
    assign spurious = empty && io_resp_v_i;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            if (push) begin
                rr_q     <= (sel == id_width_lp'(num_req_p - 1)) ? '0 : sel + id_width_lp'(1);
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + cnt_width_lp'(1);
                2'b01:   count_q <= count_q - cnt_width_lp'(1);
                default: count_q <= count_q;
            endcase
            if (spurious) begin
                error_q <= 1'b1;
            end
        end
    end

    // NOTE: the tag storage has no reset; entries are only read after being written behind count_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= sel;
        end
    end

    assign outstanding_o = count_q;
    assign error_o       = error_q;

endmodule
